// File: rtl/m3_rob_writeback_pkg.sv
// Shared widths and the packed result word carried from M3 to the ROB write port.
package m3_rob_writeback_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int INSTR_TYPE_SZ   = 3;
  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int M3_WB_DEPTH     = 4;
  localparam int CNT_W           = $clog2(M3_WB_DEPTH) + 1;

  typedef logic [WORD_SIZE-1:0]       word_t;
  typedef logic [INSTR_TYPE_SZ-1:0]   instr_type_t;
  typedef logic [ROB_ENTRY_WIDTH-1:0] rob_id_t;
  typedef logic [CNT_W-1:0]           count_t;

  typedef struct packed {
    instr_type_t instr_type;
    word_t       pc;
    word_t       value;
    rob_id_t     rob_id;
  } wb_entry_t;

endpackage

// File: rtl/m3_rob_writeback_if.sv
// M3-result input side and ROB result-write side of the writeback buffer.
interface m3_rob_writeback_if
  import m3_rob_writeback_pkg::*;
  ();

  logic        flush;
  logic        valid_in;
  instr_type_t instruction_type_in;
  word_t       pc_in;
  word_t       aluResult_in;
  rob_id_t     rob_id_in;
  logic        stall_out;

  logic        rob_wr_valid;
  logic        rob_wr_ready;
  instr_type_t rob_wr_type;
  word_t       rob_wr_pc;
  word_t       rob_wr_value;
  rob_id_t     rob_wr_id;

  count_t      count_out;
  logic        overflow_err;

  modport master (
    output flush, valid_in, instruction_type_in, pc_in, aluResult_in, rob_id_in, rob_wr_ready,
    input  stall_out, rob_wr_valid, rob_wr_type, rob_wr_pc, rob_wr_value, rob_wr_id,
           count_out, overflow_err
  );

  modport slave (
    input  flush, valid_in, instruction_type_in, pc_in, aluResult_in, rob_id_in, rob_wr_ready,
    output stall_out, rob_wr_valid, rob_wr_type, rob_wr_pc, rob_wr_value, rob_wr_id,
           count_out, overflow_err
  );

endinterface

// File: rtl/m3_rob_writeback_sync_fifo.sv
// Power-of-two synchronous FIFO with occupancy count and synchronous clear.
module m3_rob_writeback_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide which words are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/m3_rob_writeback.sv
// Buffers M3 results in order ahead of the ROB write port; stalls M3 when full.
module m3_rob_writeback
  import m3_rob_writeback_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  m3_rob_writeback_if.slave wb
);

  wb_entry_t push_entry, head_entry;
  logic      full, empty, push, pop;
  logic      overflow_err_q, overflow_err_d;

  assign push_entry = '{instr_type: wb.instruction_type_in,
                        pc:         wb.pc_in,
                        value:      wb.aluResult_in,
                        rob_id:     wb.rob_id_in};

  // A result arriving during a flush belongs to the squashed path and is dropped.
  assign push = wb.valid_in && !full && !wb.flush;
  assign pop  = !empty && wb.rob_wr_ready;

  m3_rob_writeback_sync_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (M3_WB_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (wb.flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty),
    .count (wb.count_out)
  );

  always_comb begin
    overflow_err_d = overflow_err_q;
    if (wb.flush)                overflow_err_d = 1'b0;
    else if (wb.valid_in && full) overflow_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_err_q <= 1'b0;
    else          overflow_err_q <= overflow_err_d;
  end

  assign wb.stall_out    = full;
  assign wb.overflow_err = overflow_err_q;
  assign wb.rob_wr_valid = !empty;
  assign wb.rob_wr_type  = head_entry.instr_type;
  assign wb.rob_wr_pc    = head_entry.pc;
  assign wb.rob_wr_value = head_entry.value;
  assign wb.rob_wr_id    = head_entry.rob_id;

endmodule

// File: tb/tb_m3_rob_writeback.sv
// Randomised and directed scoreboard bench for m3_rob_writeback.
module tb_m3_rob_writeback;
  import m3_rob_writeback_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  m3_rob_writeback_if bus ();

  m3_rob_writeback dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: an occupancy count plus a queue of results still owed to the ROB.
  wb_entry_t exp_q [$];
  int        m_cnt = 0;
  bit        m_ovf = 1'b0;
  bit        m_push, m_pop;
  wb_entry_t m_entry, got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else if (bus.flush) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      m_pop  = (m_cnt > 0) && bus.rob_wr_ready;
      m_push = bus.valid_in && (m_cnt < M3_WB_DEPTH);
      if (bus.valid_in && m_cnt == M3_WB_DEPTH) m_ovf = 1'b1;
      if (m_push) begin
        m_entry = '{instr_type: bus.instruction_type_in, pc: bus.pc_in,
                    value: bus.aluResult_in, rob_id: bus.rob_id_in};
        exp_q.push_back(m_entry);
      end
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
    end
  end

  // Monitor: compares status every cycle and the head entry whenever a ROB write will complete.
  always @(negedge clk) begin
    check("rob_wr_valid", 32'(bus.rob_wr_valid), 32'(m_cnt > 0));
    check("count_out", 32'(bus.count_out), 32'(m_cnt));
    check("stall_out", 32'(bus.stall_out), 32'(m_cnt == M3_WB_DEPTH));
    check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
    if (reset_n && m_cnt > 0 && bus.rob_wr_ready) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underrun", 32'(exp_q.size()), 32'd1);
      end else begin
        got = exp_q.pop_front();
        check("rob_wr_id", 32'(bus.rob_wr_id), 32'(got.rob_id));
        check("rob_wr_value", bus.rob_wr_value, got.value);
        check("rob_wr_pc", bus.rob_wr_pc, got.pc);
        check("rob_wr_type", 32'(bus.rob_wr_type), 32'(got.instr_type));
      end
    end
  end

  task automatic cycle(input logic v, input rob_id_t id, input word_t val,
                       input logic rdy, input logic fl);
    bus.valid_in            = v;
    bus.rob_id_in           = id;
    bus.aluResult_in        = val;
    bus.pc_in               = $urandom;
    bus.instruction_type_in = instr_type_t'($urandom);
    bus.rob_wr_ready        = rdy;
    bus.flush               = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.rob_id_in = '0;
    bus.aluResult_in = '0;
    bus.pc_in = '0;
    bus.instruction_type_in = '0;
    bus.rob_wr_ready = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("rst_count", 32'(bus.count_out), 32'd0);
    check("rst_valid", 32'(bus.rob_wr_valid), 32'd0);
    check("rst_stall", 32'(bus.stall_out), 32'd0);
    check("rst_ovf", 32'(bus.overflow_err), 32'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Single result, visible one edge after the push for exactly one cycle.
    cycle(1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 1'b0);
    check("single_valid", 32'(bus.rob_wr_valid), 32'd1);
    check("single_id", 32'(bus.rob_wr_id), 32'd3);
    check("single_value", bus.rob_wr_value, 32'hDEADBEEF);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("single_gone", 32'(bus.rob_wr_valid), 32'd0);

    // Backpressure fill, overflow, then in-order drain.
    for (int i = 0; i < 4; i++) cycle(1'b1, rob_id_t'(i), $urandom, 1'b0, 1'b0);
    check("fill_stall", 32'(bus.stall_out), 32'd1);
    check("fill_count", 32'(bus.count_out), 32'd4);
    cycle(1'b1, 3'd5, $urandom, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.overflow_err), 32'd1);
    check("ovf_count", 32'(bus.count_out), 32'd4);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_stall_drop", 32'(bus.stall_out), 32'd0);
    check("drain_count3", 32'(bus.count_out), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(bus.count_out), 32'd0);
    check("ovf_sticky", 32'(bus.overflow_err), 32'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    check("ovf_flush_clear", 32'(bus.overflow_err), 32'd0);

    // Simultaneous push and pop at occupancy 2; pointers wrap several times.
    cycle(1'b1, 3'd1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, rob_id_t'(i), $urandom, 1'b1, 1'b0);
      check("pushpop_count", 32'(bus.count_out), 32'd2);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush mid-drain alongside a new result.
    for (int i = 0; i < 3; i++) cycle(1'b1, rob_id_t'(i + 4), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, $urandom, 1'b1, 1'b1);
    check("flush_count", 32'(bus.count_out), 32'd0);
    check("flush_valid", 32'(bus.rob_wr_valid), 32'd0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries held.
    cycle(1'b1, 3'd2, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, $urandom, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", 32'(bus.count_out), 32'd0);
    check("arst_valid", 32'(bus.rob_wr_valid), 32'd0);
    check("arst_stall", 32'(bus.stall_out), 32'd0);
    check("arst_ovf", 32'(bus.overflow_err), 32'd0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    reset_n = 1'b1;
    cycle(1'b1, 3'd4, $urandom, 1'b1, 1'b0);
    check("post_rst_valid", 32'(bus.rob_wr_valid), 32'd1);
    check("post_rst_id", 32'(bus.rob_wr_id), 32'd4);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), rob_id_t'($urandom), $urandom,
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
